serial_add_sequencer: RTL and testbench
=======================================

# serial_add_sequencer

Bit-serial add/subtract sequencer for the team's 1-bit adder datapath (XOR sum, AND carry half-adder cells). It captures two WIDTH-bit operands and steps one full-adder slice across them LSB-first, one bit per enabled clock. The full adder is two half-adder cells plus a registered carry. It provides a start/busy/done handshake and sits between the pin-level input registers and the result output mux of the tile.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range 2..32.
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  clock-enable. When low, all state is frozen and start is ignored.
- start  input  1  request pulse. Sampled only when ena=1 and the FSM is in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A−B. Sampled with start.
- op_a  input  WIDTH  operand A, sampled with start.
- op_b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE; one cycle when ena stays high.
- sum  output  WIDTH  result register.
- carry_out  output  1  final carry. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement overflow of the last result.

## Operation
- States: IDLE, RUN, DONE. Encoding is free; outputs are decoded from registers only.
- IDLE/DONE, start=1 and ena=1: load the shift registers.
  - sa = op_a; sb = sub ? ~op_b : op_b.
  - c = sub; bit counter = 0.
  - Next state RUN.
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE.
- RUN, each edge with ena=1, one bit step:
  - s = sa[0]^sb[0]^c; c ← (sa[0]&sb[0]) | (c&(sa[0]^sb[0])).
  - sa, sb shift right; s shifts into the MSB of the result shift register; counter increments.
- RUN, step with counter = WIDTH−1 (the last bit):
  - Next state DONE.
  - sum ← completed result; carry_out ← new c.
  - overflow ← (carry into MSB) ^ (carry out of MSB).
- start in RUN is ignored; no queuing.
- sum, carry_out and overflow change only on the completion edge. They hold their values through IDLE, DONE and the whole of the next operation.
- Arithmetic is modulo 2^WIDTH. Subtract is A + ~B + 1.

## Timing
- Reset (async assert, applies at any time including mid-RUN):
  - State goes to IDLE immediately.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Shift registers, counter and carry are cleared.
  - Operation resumes on the first clock edge after rst_n rises.
- Start accepted at edge E0: busy=1 after E0.
- With ena held high:
  - Bit steps occur at edges E1..E_WIDTH.
  - After E_WIDTH: busy=0, done=1, results valid.
  - Latency from accept to done is WIDTH cycles.
  - done drops after E_WIDTH+1 unless a new start is accepted there. In that case done=0 and busy=1 after that edge.
- Back-to-back throughput: one operation per WIDTH+1 cycles.
- ena low for k cycles during RUN:
  - No bit step during those cycles.
  - Latency becomes WIDTH+k.
  - Results are identical to the unstalled case.
- ena low in DONE holds done=1 until ena returns and the FSM leaves DONE.
- done and busy are never high in the same cycle.

## Test plan
- Reset values: assert rst_n=0 mid-run → all outputs 0 immediately.
- Add with signed overflow, WIDTH=8: start with op_a=0x5A, op_b=0x3C, sub=0 → done exactly 8 cycles after the accept edge with sum=0x96, carry_out=0, overflow=1. busy is high for exactly 8 cycles.
- Add with unsigned wrap: op_a=0xFF, op_b=0x01, sub=0 → sum=0x00, carry_out=1, overflow=0.
- Subtract with borrow, then back-to-back subtract:
  - 0x10−0x20 → sum=0xF0, carry_out=0, overflow=0.
  - Then start held high in the DONE cycle with 0x80−0x01 → accepted with no idle gap.
  - Second result: sum=0x7F, carry_out=1, overflow=1.
  - Previous sum stays 0xF0 until the second completion.
- Stall and ignored start:
  - During RUN, pulse start with new operands and drop ena for 3 cycles.
  - Required: the extra start is ignored, done arrives 11 cycles after the accept edge, and the result matches the unstalled value.
- Reset mid-operation:
  - Drop rst_n at bit step 4 → busy, done and sum read 0 immediately.
  - After release, a fresh 0x01+0x01 yields sum=0x02 with no residue from the aborted operation.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer: one full-adder slice (two half-adder cells plus a registered carry)
// stepped LSB-first across two captured WIDTH-bit operands, with a start/busy/done handshake.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             c;

  logic load;
  logic step;
  logic last;

  logic ha1_s, ha1_c, ha2_s, ha2_c, c_new;

  // Full adder built from two half-adder cells; c is the registered carry between bit steps.
  assign ha1_s = sa[0] ^ sb[0];
  assign ha1_c = sa[0] & sb[0];
  assign ha2_s = ha1_s ^ c;
  assign ha2_c = ha1_s & c;
  assign c_new = ha1_c | ha2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    busy       = (state == RUN);
    done       = (state == DONE);
    case (state)
      IDLE: begin
        if (ena && start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (ena) begin
          step = 1'b1;
          if (cnt == LAST_BIT) begin
            last       = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (ena) begin
          if (start) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only move on the completion step, so they hold through the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      res       <= '0;
      cnt       <= '0;
      c         <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      sa  <= op_a;
      sb  <= sub ? ~op_b : op_b;
      c   <= sub;
      cnt <= '0;
      res <= '0;
    end else if (step) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= {ha2_s, res[WIDTH-1:1]};
      c   <= c_new;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum       <= {ha2_s, res[WIDTH-1:1]};
        carry_out <= c_new;
        overflow  <= c ^ c_new;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: directed vector table, stall/back-to-back/reset
// sequences and randomized operations compared against an arithmetic reference model.
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] prev_sum;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .sub(sub),
    .op_a(op_a),
    .op_b(op_b),
    .busy(busy),
    .done(done),
    .sum(sum),
    .carry_out(carry_out),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    int         stall;
    bit         b2b;
    logic [7:0] es;
    logic       ec;
    logic       eo;
    string      name;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
  function automatic void refModel(input logic [7:0] a, input logic [7:0] b, input logic s,
                                   output logic [7:0] rs, output logic rc, output logic ro);
    int ia, ib, r, sa_i, sb_i, sr;
    ia = int'(a);
    ib = int'(b);
    r  = s ? ia - ib : ia + ib;
    rs = r[7:0];
    rc = s ? (ia >= ib) : (r >= 256);
    sa_i = (ia >= 128) ? ia - 256 : ia;
    sb_i = (ib >= 128) ? ib - 256 : ib;
    sr = s ? sa_i - sb_i : sa_i + sb_i;
    ro = (sr > 127) || (sr < -128);
  endfunction

  task automatic idleCycle(input string name);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  // Called at a negedge; drives one operation and follows it to completion.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s,
                               input int stall, input logic [7:0] es, input logic ec,
                               input logic eo, input string name);
    int cycles;
    int busy_cnt;
    bit hold_ok;
    bit excl_ok;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    ena   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a  = 8'($urandom);
    op_b  = 8'($urandom);
    checkOutput({name, "_accept"}, {30'd0, busy, done}, 32'd2);
    hold_ok  = (sum === prev_sum);
    excl_ok  = 1'b1;
    busy_cnt = busy ? 1 : 0;
    cycles   = 0;
    while (!done && cycles < 100) begin
      if (stall > 0 && cycles == 1) begin
        start = 1'b1;
        sub   = ~s;
        op_a  = ~a;
      end
      if (stall > 0 && cycles == 2) begin
        start = 1'b0;
        ena   = 1'b0;
      end
      if (stall > 0 && cycles == 2 + stall) ena = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (busy && done) excl_ok = 1'b0;
      if (!done && sum !== prev_sum) hold_ok = 1'b0;
    end
    ena = 1'b1;
    checkOutput({name, "_latency"}, cycles, WIDTH + stall);
    checkOutput({name, "_busy_cycles"}, busy_cnt, WIDTH + stall);
    checkOutput({name, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({name, "_sum"}, {24'd0, sum}, {24'd0, es});
    checkOutput({name, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
    checkOutput({name, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    checkOutput({name, "_hold"}, {31'd0, hold_ok}, 32'd1);
    checkOutput({name, "_excl"}, {31'd0, excl_ok}, 32'd1);
    prev_sum = es;
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc, ro;
    logic [7:0] ra, rb;
    logic       rsub;
    int         rstall;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 0, 1'b0, 8'h96, 1'b0, 1'b1, "add_ovf"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, "add_wrap"};
    vecs[2] = '{8'h10, 8'h20, 1'b1, 0, 1'b0, 8'hF0, 1'b0, 1'b0, "sub_borrow"};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_b2b"};
    vecs[4] = '{8'h5A, 8'h3C, 1'b0, 3, 1'b0, 8'h96, 1'b0, 1'b1, "stall3"};

    rst_n    = 1'b0;
    ena      = 1'b1;
    start    = 1'b0;
    sub      = 1'b0;
    op_a     = '0;
    op_b     = '0;
    prev_sum = '0;
    #1;
    checkOutput("reset_outputs", {busy, done, carry_out, overflow, sum},
                {4'b0000, 8'h00});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (!vecs[i].b2b) idleCycle(vecs[i].name);
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].stall,
                    vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].name);
    end

    // done must hold while ena is low in DONE
    ena = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("done_frozen", {31'd0, done}, 32'd1);
    ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_release", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 25; i++) begin
      ra     = 8'($urandom);
      rb     = 8'($urandom);
      rsub   = 1'($urandom_range(0, 1));
      rstall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      refModel(ra, rb, rsub, rs, rc, ro);
      if ($urandom_range(0, 1) == 0) idleCycle("rand");
      applyStimulus(ra, rb, rsub, rstall, rs, rc, ro, "rand");
    end

    // Abort an operation after its fourth bit step
    idleCycle("pre_reset");
    op_a  = 8'h5A;
    op_b  = 8'h3C;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset", {busy, done, carry_out, overflow, sum},
                {4'b0000, 8'h00});
    prev_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0, 1'b0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
